conv_stream_driver: RTL and testbench

On-chip stimulus source and response collector for the Convolution block; it is the initiator end of the Convolution streaming interface.
- Holds three 100-entry 5-bit pixel channels and 24 signed 8-bit kernel weights, loaded through a config write port.
- On START, streams the pixels and weights with the IN_VALID/KERNEL_VALID timing Convolution expects.
- Captures the 88 OUT_DATA results into a readable buffer and flags protocol errors (late first output, gaps, overflow).

---
 rtl/conv_stream_driver_if.sv | 47 ++++
 rtl/conv_stream_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_conv_stream_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_driver_if.sv
// Streaming, config and result-readback bundle between conv_stream_driver
// (master view) and the Convolution block / host (slave view).
interface conv_stream_driver_if #(
  parameter int DATA_W = 5,
  parameter int KER_W  = 8,
  parameter int OUT_W  = 32
);
  // Config write port
  logic                     CFG_WE;
  logic [2:0]               CFG_SEL;
  logic [6:0]               CFG_ADDR;
  logic [31:0]              CFG_WDATA;
  // Frame control and status
  logic                     START;
  logic                     BUSY;
  logic                     DONE;
  // Stimulus streams towards Convolution
  logic [DATA_W-1:0]        IN_DATA_1;
  logic [DATA_W-1:0]        IN_DATA_2;
  logic [DATA_W-1:0]        IN_DATA_3;
  logic                     IN_VALID;
  logic signed [KER_W-1:0]  KERNEL;
  logic                     KERNEL_VALID;
  // Responses from Convolution
  logic [OUT_W-1:0]         OUT_DATA;
  logic                     OUT_VALID;
  // Result buffer readback and error flags
  logic [6:0]               RES_ADDR;
  logic [OUT_W-1:0]         RES_DATA;
  logic [6:0]               OUT_COUNT;
  logic                     ERR_TIMEOUT;
  logic                     ERR_GAP;
  logic                     ERR_OVERFLOW;
  logic                     ERR_MISMATCH;

  modport master (
    input  CFG_WE, CFG_SEL, CFG_ADDR, CFG_WDATA, START, OUT_DATA, OUT_VALID, RES_ADDR,
    output BUSY, DONE, IN_DATA_1, IN_DATA_2, IN_DATA_3, IN_VALID, KERNEL, KERNEL_VALID,
           RES_DATA, OUT_COUNT, ERR_TIMEOUT, ERR_GAP, ERR_OVERFLOW, ERR_MISMATCH
  );

  modport slave (
    output CFG_WE, CFG_SEL, CFG_ADDR, CFG_WDATA, START, OUT_DATA, OUT_VALID, RES_ADDR,
    input  BUSY, DONE, IN_DATA_1, IN_DATA_2, IN_DATA_3, IN_VALID, KERNEL, KERNEL_VALID,
           RES_DATA, OUT_COUNT, ERR_TIMEOUT, ERR_GAP, ERR_OVERFLOW, ERR_MISMATCH
  );
endinterface

// File: rtl/conv_stream_driver.sv
// conv_stream_driver: stimulus source and response collector for the
// Convolution block. Streams three pixel channels plus kernel weights on
// START, captures the results into a readable buffer and flags late first
// output, gaps and overflow.
// Optional macro GOLDEN_CMP_EN adds a golden memory (CFG_SEL = 4) and a
// sticky ERR_MISMATCH compare of every captured result.
module conv_stream_driver #(
  parameter int DATA_W          = 5,
  parameter int KER_W           = 8,
  parameter int OUT_W           = 32,
  parameter int N_IN            = 100,
  parameter int N_KER           = 24,
  parameter int N_OUT           = 88,
  parameter int FIRST_OUT_LIMIT = 38
) (
  input logic                  CLK,
  input logic                  RESET,
  conv_stream_driver_if.master bus
);

  localparam logic [6:0] N_IN_L     = 7'(N_IN);
  localparam logic [6:0] N_KER_L    = 7'(N_KER);
  localparam logic [6:0] N_OUT_L    = 7'(N_OUT);
  localparam logic [6:0] LAST_K     = 7'(N_IN - 1);
  localparam logic [6:0] LIMIT_L    = 7'(FIRST_OUT_LIMIT);
  // The counter value that, once reached with nothing captured, means late.
  localparam logic [6:0] TIMEOUT_AT = 7'(FIRST_OUT_LIMIT - 1);
  localparam int         KIDX_W     = $clog2(N_KER);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  // Frame memories; none of them is touched by reset.
  logic [DATA_W-1:0]       pix1_mem [N_IN];
  logic [DATA_W-1:0]       pix2_mem [N_IN];
  logic [DATA_W-1:0]       pix3_mem [N_IN];
  logic signed [KER_W-1:0] ker_mem  [N_KER];
  logic [OUT_W-1:0]        res_mem  [N_OUT];
`ifdef GOLDEN_CMP_EN
  logic [OUT_W-1:0]        golden_mem [N_OUT];
`endif

  state_t                  state_q, state_d;
  logic [6:0]              k_q, k_d;
  logic [6:0]              cyc_q, cyc_d;
  logic [6:0]              out_count_q, out_count_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    in_valid_q, in_valid_d;
  logic [DATA_W-1:0]       in_data_1_q, in_data_1_d;
  logic [DATA_W-1:0]       in_data_2_q, in_data_2_d;
  logic [DATA_W-1:0]       in_data_3_q, in_data_3_d;
  logic                    kernel_valid_q, kernel_valid_d;
  logic signed [KER_W-1:0] kernel_q, kernel_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    err_gap_q, err_gap_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    err_mismatch_q, err_mismatch_d;
  logic [OUT_W-1:0]        res_data_q, res_data_d;

  logic                    cfg_en;
  logic                    active;
  logic                    capture;
  logic                    golden_miss;

  // Upper write-data bits carry nothing for the narrow targets.
  wire unused_cfg_bits = &{1'b0, bus.CFG_WDATA[31:KER_W]};

  // Config is only accepted while no frame is running. Once a timeout or gap
  // has been recorded the frame is abandoned and the buffer keeps only the
  // contiguous prefix of results.
  always_comb begin
    cfg_en  = bus.CFG_WE && ((state_q == S_IDLE) || (state_q == S_DONE));
    active  = (state_q == S_STREAM) || (state_q == S_DRAIN);
    capture = active && bus.OUT_VALID && (out_count_q < N_OUT_L) &&
              !err_timeout_q && !err_gap_q;
  end

`ifdef GOLDEN_CMP_EN
  assign golden_miss = capture && (bus.OUT_DATA != golden_mem[out_count_q]);
`else
  assign golden_miss = 1'b0;
`endif

  // Next-state, stream and error-flag computation for the frame sequencer.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    cyc_d          = cyc_q;
    out_count_d    = capture ? (out_count_q + 7'd1) : out_count_q;
    err_timeout_d  = err_timeout_q |
                     (active && (cyc_q == TIMEOUT_AT) && (out_count_q == 7'd0) && !capture);
    err_gap_d      = err_gap_q |
                     (active && !bus.OUT_VALID && (out_count_q != 7'd0) && (out_count_q < N_OUT_L));
    err_overflow_d = err_overflow_q |
                     ((state_q != S_IDLE) && bus.OUT_VALID && (out_count_q == N_OUT_L));
    err_mismatch_d = err_mismatch_q | golden_miss;
    in_valid_d     = 1'b0;
    kernel_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          state_d        = S_STREAM;
          k_d            = 7'd0;
          cyc_d          = 7'd0;
          out_count_d    = 7'd0;
          err_timeout_d  = 1'b0;
          err_gap_d      = 1'b0;
          err_overflow_d = 1'b0;
          err_mismatch_d = 1'b0;
          in_valid_d     = 1'b1;
          kernel_valid_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (cyc_q < LIMIT_L) cyc_d = cyc_q + 7'd1;
        if (k_q == LAST_K) begin
          state_d = S_DRAIN;
        end else begin
          k_d            = k_q + 7'd1;
          in_valid_d     = 1'b1;
          kernel_valid_d = (k_d < N_KER_L);
        end
      end
      S_DRAIN: begin
        if (cyc_q < LIMIT_L) cyc_d = cyc_q + 7'd1;
        if ((out_count_d == N_OUT_L) || err_timeout_d || err_gap_d) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);

    // Data outputs are forced to zero whenever their valid is low.
    in_data_1_d = '0;
    in_data_2_d = '0;
    in_data_3_d = '0;
    if (in_valid_d) begin
      in_data_1_d = pix1_mem[k_d];
      in_data_2_d = pix2_mem[k_d];
      in_data_3_d = pix3_mem[k_d];
    end
    kernel_d = '0;
    if (kernel_valid_d) kernel_d = ker_mem[k_d[KIDX_W-1:0]];

    res_data_d = (bus.RES_ADDR < N_OUT_L) ? res_mem[bus.RES_ADDR] : '0;
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      cyc_q          <= '0;
      out_count_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      in_valid_q     <= 1'b0;
      in_data_1_q    <= '0;
      in_data_2_q    <= '0;
      in_data_3_q    <= '0;
      kernel_valid_q <= 1'b0;
      kernel_q       <= '0;
      err_timeout_q  <= 1'b0;
      err_gap_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      err_mismatch_q <= 1'b0;
      res_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cyc_q          <= cyc_d;
      out_count_q    <= out_count_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      in_valid_q     <= in_valid_d;
      in_data_1_q    <= in_data_1_d;
      in_data_2_q    <= in_data_2_d;
      in_data_3_q    <= in_data_3_d;
      kernel_valid_q <= kernel_valid_d;
      kernel_q       <= kernel_d;
      err_timeout_q  <= err_timeout_d;
      err_gap_q      <= err_gap_d;
      err_overflow_q <= err_overflow_d;
      err_mismatch_q <= err_mismatch_d;
      res_data_q     <= res_data_d;
    end
  end

  // Memory writes: config loads (range-checked per target) and result capture.
  always_ff @(posedge CLK) begin
    if (cfg_en) begin
      case (bus.CFG_SEL)
        3'd0: if (bus.CFG_ADDR < N_IN_L)  pix1_mem[bus.CFG_ADDR] <= bus.CFG_WDATA[DATA_W-1:0];
        3'd1: if (bus.CFG_ADDR < N_IN_L)  pix2_mem[bus.CFG_ADDR] <= bus.CFG_WDATA[DATA_W-1:0];
        3'd2: if (bus.CFG_ADDR < N_IN_L)  pix3_mem[bus.CFG_ADDR] <= bus.CFG_WDATA[DATA_W-1:0];
        3'd3: if (bus.CFG_ADDR < N_KER_L) ker_mem[bus.CFG_ADDR[KIDX_W-1:0]] <= bus.CFG_WDATA[KER_W-1:0];
`ifdef GOLDEN_CMP_EN
        3'd4: if (bus.CFG_ADDR < N_OUT_L) golden_mem[bus.CFG_ADDR] <= bus.CFG_WDATA;
`endif
        default: ;
      endcase
    end
    if (capture) res_mem[out_count_q] <= bus.OUT_DATA;
  end

  assign bus.BUSY         = busy_q;
  assign bus.DONE         = done_q;
  assign bus.IN_VALID     = in_valid_q;
  assign bus.IN_DATA_1    = in_data_1_q;
  assign bus.IN_DATA_2    = in_data_2_q;
  assign bus.IN_DATA_3    = in_data_3_q;
  assign bus.KERNEL_VALID = kernel_valid_q;
  assign bus.KERNEL       = kernel_q;
  assign bus.OUT_COUNT    = out_count_q;
  assign bus.RES_DATA     = res_data_q;
  assign bus.ERR_TIMEOUT  = err_timeout_q;
  assign bus.ERR_GAP      = err_gap_q;
  assign bus.ERR_OVERFLOW = err_overflow_q;
  assign bus.ERR_MISMATCH = err_mismatch_q;

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver: a cycle-by-cycle response model
// drives OUT_VALID/OUT_DATA while the stream outputs are logged per cycle and
// compared against hand-computed values.
module tb_conv_stream_driver;

  localparam int FRAME_CYC = 130;

`ifdef GOLDEN_CMP_EN
  localparam logic EXP_MISMATCH = 1'b1;
`else
  localparam logic EXP_MISMATCH = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;

  conv_stream_driver_if bus ();

  conv_stream_driver dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cyc_g;

  logic       iv_log   [FRAME_CYC];
  logic       kv_log   [FRAME_CYC];
  logic       tout_log [FRAME_CYC];
  logic       gap_log  [FRAME_CYC];
  logic [7:0] ker_log  [FRAME_CYC];
  logic [4:0] d1_log   [FRAME_CYC];
  logic [4:0] d2_log   [FRAME_CYC];
  logic [4:0] d3_log   [FRAME_CYC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic cfg_write(input int sel, input int addr, input logic [31:0] data);
    @(negedge CLK);
    bus.CFG_WE    = 1'b1;
    bus.CFG_SEL   = 3'(sel);
    bus.CFG_ADDR  = 7'(addr);
    bus.CFG_WDATA = data;
    @(negedge CLK);
    bus.CFG_WE    = 1'b0;
  endtask

  task automatic read_res(input int addr, output logic [31:0] d);
    bus.RES_ADDR = 7'(addr);
    @(negedge CLK);
    d = bus.RES_DATA;
    bus.RES_ADDR = 7'd127;
  endtask

  // One frame: START pulse, then FRAME_CYC cycles of response model and logging.
  // Cycle c is the c-th cycle after the edge that accepts START (IN_VALID k = c).
  task automatic run_frame(input string name, input int first, input int nres,
                           input int drop_cyc, input int bad_idx, input int rst_cyc);
    int sent;
    int done_cyc;
    sent = 0;
    done_cyc = -1;
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    for (int c = 0; c < FRAME_CYC; c++) begin
      iv_log[c]   = bus.IN_VALID;
      kv_log[c]   = bus.KERNEL_VALID;
      tout_log[c] = bus.ERR_TIMEOUT;
      gap_log[c]  = bus.ERR_GAP;
      ker_log[c]  = bus.KERNEL;
      d1_log[c]   = bus.IN_DATA_1;
      d2_log[c]   = bus.IN_DATA_2;
      d3_log[c]   = bus.IN_DATA_3;
      if (bus.DONE && done_cyc < 0) done_cyc = c;
      if (c == rst_cyc) begin
        RESET = 1'b0;
        bus.OUT_VALID = 1'b0;
        bus.OUT_DATA  = '0;
        @(negedge CLK);
        check("rst_in_valid", 32'(bus.IN_VALID), 32'd0);
        check("rst_kernel_valid", 32'(bus.KERNEL_VALID), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_out_count", 32'(bus.OUT_COUNT), 32'd0);
        check("rst_res_data", bus.RES_DATA, 32'd0);
        RESET = 1'b1;
        $display("frame %s: reset asserted at stream cycle %0d, results sent %0d", name, c, sent);
        return;
      end
      // Side traffic that must be ignored while the frame is running.
      bus.CFG_WE    = (c == 0);
      bus.CFG_SEL   = 3'd0;
      bus.CFG_ADDR  = 7'd3;
      bus.CFG_WDATA = 32'd9;
      bus.START     = (c == 10);
      if (c >= first && sent < nres && c != drop_cyc) begin
        bus.OUT_VALID = 1'b1;
        bus.OUT_DATA  = (sent == bad_idx) ? 32'd8 : 32'(1000 + sent);
        sent++;
      end else begin
        bus.OUT_VALID = 1'b0;
        bus.OUT_DATA  = '0;
      end
      @(negedge CLK);
    end
    bus.OUT_VALID = 1'b0;
    bus.OUT_DATA  = '0;
    bus.CFG_WE    = 1'b0;
    bus.START     = 1'b0;
    done_cyc_g    = done_cyc;
    $display("frame %s: done_cycle=%0d out_count=%0d err{t,g,o,m}=%b%b%b%b results_sent=%0d",
             name, done_cyc, bus.OUT_COUNT, bus.ERR_TIMEOUT, bus.ERR_GAP,
             bus.ERR_OVERFLOW, bus.ERR_MISMATCH, sent);
  endtask

  function automatic int count_iv();
    int n = 0;
    for (int i = 0; i < FRAME_CYC; i++) if (iv_log[i]) n++;
    return n;
  endfunction

  function automatic int count_kv();
    int n = 0;
    for (int i = 0; i < FRAME_CYC; i++) if (kv_log[i]) n++;
    return n;
  endfunction

  initial begin
    logic [31:0] rd;
    RESET         = 1'b0;
    bus.CFG_WE    = 1'b0;
    bus.CFG_SEL   = 3'd0;
    bus.CFG_ADDR  = 7'd0;
    bus.CFG_WDATA = '0;
    bus.START     = 1'b0;
    bus.OUT_DATA  = '0;
    bus.OUT_VALID = 1'b0;
    bus.RES_ADDR  = 7'd127;
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_in_valid", 32'(bus.IN_VALID), 32'd0);
    check("reset_res_data", bus.RES_DATA, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check("idle_done", 32'(bus.DONE), 32'd0);
    check("idle_out_count", 32'(bus.OUT_COUNT), 32'd0);
    check("idle_res_oob", bus.RES_DATA, 32'd0);

    // Memory load.
    for (int k = 0; k < 100; k++) begin
      cfg_write(0, k, 32'(k % 32));
      cfg_write(1, k, 32'((k * 3) % 32));
      cfg_write(2, k, 32'(31 - (k % 32)));
    end
    for (int k = 0; k < 24; k++) cfg_write(3, k, 32'(k - 12));
    for (int i = 0; i < 88; i++) cfg_write(4, i, 32'(1000 + i));
    cfg_write(5, 3, 32'd31);
    $display("config: loaded 3x100 pixels, 24 kernel words, 88 golden words");

    // Normal frame: results start 20 cycles after first IN_VALID.
    run_frame("normal", 20, 88, -1, -1, -1);
    check("iv_count", 32'(count_iv()), 32'd100);
    check("kv_count", 32'(count_kv()), 32'd24);
    check("kv_cycle23", 32'(kv_log[23]), 32'd1);
    check("kv_cycle24", 32'(kv_log[24]), 32'd0);
    check("kernel_cycle0", 32'(ker_log[0]), 32'hF4);
    check("kernel_cycle23", 32'(ker_log[23]), 32'h0B);
    check("kernel_cycle24_zero", 32'(ker_log[24]), 32'd0);
    check("in1_cycle3", 32'(d1_log[3]), 32'd3);
    check("in2_cycle3", 32'(d2_log[3]), 32'd9);
    check("in3_cycle99", 32'(d3_log[99]), 32'd28);
    check("iv_cycle100", 32'(iv_log[100]), 32'd0);
    check("in1_cycle100_zero", 32'(d1_log[100]), 32'd0);
    check("normal_done_cycle", 32'(done_cyc_g), 32'd108);
    check("normal_out_count", 32'(bus.OUT_COUNT), 32'd88);
    check("normal_errs", {28'd0, bus.ERR_TIMEOUT, bus.ERR_GAP, bus.ERR_OVERFLOW, bus.ERR_MISMATCH}, 32'd0);
    read_res(87, rd);
    check("res87", rd, 32'd1087);
    read_res(0, rd);
    check("res0", rd, 32'd1000);
    read_res(100, rd);
    check("res_oob", rd, 32'd0);

    // Reset mid-stream at k = 40, then a clean restream.
    run_frame("reset_mid", 20, 88, -1, -1, 40);
    @(negedge CLK);
    run_frame("restream", 20, 88, -1, -1, -1);
    check("restream_kernel0", 32'(ker_log[0]), 32'hF4);
    check("restream_in1_cycle3", 32'(d1_log[3]), 32'd3);
    check("restream_in3_cycle0", 32'(d3_log[0]), 32'd31);
    check("restream_iv_count", 32'(count_iv()), 32'd100);
    check("restream_done_cycle", 32'(done_cyc_g), 32'd108);
    check("restream_out_count", 32'(bus.OUT_COUNT), 32'd88);

    // No responses at all: timeout visible on cycle 38.
    run_frame("timeout", 20, 0, -1, -1, -1);
    check("timeout_cycle37", 32'(tout_log[37]), 32'd0);
    check("timeout_cycle38", 32'(tout_log[38]), 32'd1);
    check("timeout_done_cycle", 32'(done_cyc_g), 32'd101);
    check("timeout_out_count", 32'(bus.OUT_COUNT), 32'd0);
    check("timeout_no_gap", 32'(bus.ERR_GAP), 32'd0);

    // One-cycle drop after result 10.
    run_frame("gap", 20, 88, 30, -1, -1);
    check("gap_cycle30", 32'(gap_log[30]), 32'd0);
    check("gap_cycle31", 32'(gap_log[31]), 32'd1);
    check("gap_done_cycle", 32'(done_cyc_g), 32'd101);
    check("gap_out_count", 32'(bus.OUT_COUNT), 32'd10);
    check("gap_no_timeout", 32'(bus.ERR_TIMEOUT), 32'd0);
    check("gap_no_overflow", 32'(bus.ERR_OVERFLOW), 32'd0);
    read_res(9, rd);
    check("gap_res9", rd, 32'd1009);

    // 89 contiguous results.
    run_frame("overflow", 20, 89, -1, -1, -1);
    check("ovf_flag", 32'(bus.ERR_OVERFLOW), 32'd1);
    check("ovf_done_cycle", 32'(done_cyc_g), 32'd108);
    check("ovf_out_count", 32'(bus.OUT_COUNT), 32'd88);
    check("ovf_no_gap", 32'(bus.ERR_GAP), 32'd0);
    read_res(87, rd);
    check("ovf_res87", rd, 32'd1087);

    // Golden compare: golden[5] = 7, model returns 8 at index 5.
    cfg_write(4, 5, 32'd7);
    run_frame("golden", 20, 88, -1, 5, -1);
    check("golden_mismatch", 32'(bus.ERR_MISMATCH), 32'(EXP_MISMATCH));
    check("golden_out_count", 32'(bus.OUT_COUNT), 32'd88);
    check("golden_done_cycle", 32'(done_cyc_g), 32'd108);
    check("golden_no_overflow", 32'(bus.ERR_OVERFLOW), 32'd0);
    read_res(5, rd);
    check("golden_res5", rd, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
